// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: computes result = base^exp mod n by left-to-right
// square-and-multiply. Each modular product is formed with an interleaved
// shift-add multiplier that consumes one multiplier bit per cycle, MSB first.
// Optional feature: define RSA_MODEXP_CONST_TIME_EN to run MUL for every
// exponent bit and discard its result when the bit is 0. This makes the
// latency independent of the exponent value.
module rsa_modexp_ctrl #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  // Two guard bits keep 2t + b below 2^(WIDTH+2) while t and b stay below n.
  localparam int DW = WIDTH + 2;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] base_r, exp_r, n_r;
  logic [DW-1:0]    acc, t, t_step, acc_upd, mul_b, n_ext;
  logic [WIDTH-1:0] acc_lo;
  logic [IW-1:0]    mcnt, ebit;
  logic             mul_bit, mul_last, cur_bit, bad_operands;

  assign n_ext        = {2'b00, n_r};
  assign acc_lo       = acc[WIDTH-1:0];
  assign mul_bit      = acc_lo[mcnt];
  assign mul_last     = (mcnt == '0);
  assign cur_bit      = exp_r[ebit];
  assign bad_operands = (n_r < WIDTH'(2)) || (base_r >= n_r);
  assign mul_b        = (state == SQR) ? acc : {2'b00, base_r};
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  // One shift-add modular multiply step: t = 2t mod n, then add b mod n.
  always_comb begin
    t_step = t << 1;
    if (t_step >= n_ext) t_step = t_step - n_ext;
    if (mul_bit) t_step = t_step + mul_b;
    if (t_step >= n_ext) t_step = t_step - n_ext;
  end

  // Value written to acc at the end of a SQR or MUL pass.
  always_comb begin
    acc_upd = t_step;
`ifdef RSA_MODEXP_CONST_TIME_EN
    if (state == MUL && !cur_bit) acc_upd = acc;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: walk the exponent bits MSB to LSB.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: next_state = bad_operands ? DONE : SQR;
      SQR: begin
        if (mul_last) begin
`ifdef RSA_MODEXP_CONST_TIME_EN
          next_state = MUL;
`else
          if (cur_bit)           next_state = MUL;
          else if (ebit == '0)   next_state = DONE;
          else                   next_state = SQR;
`endif
        end
      end
      MUL:  if (mul_last) next_state = (ebit == '0) ? DONE : SQR;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, multiplier stepping and result/err update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= '0;
      exp_r  <= '0;
      n_r    <= '0;
      acc    <= '0;
      t      <= '0;
      mcnt   <= '0;
      ebit   <= '0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            n_r    <= n;
            err    <= 1'b0;
          end
        end
        LOAD: begin
          if (bad_operands) begin
            err    <= 1'b1;
            result <= '0;
          end else begin
            acc  <= DW'(1);
            t    <= '0;
            mcnt <= IW'(WIDTH - 1);
            ebit <= IW'(WIDTH - 1);
          end
        end
        SQR, MUL: begin
          if (mul_last) begin
            acc  <= acc_upd;
            t    <= '0;
            mcnt <= IW'(WIDTH - 1);
            if (next_state == DONE) result <= acc_upd[WIDTH-1:0];
            if (next_state == SQR)  ebit   <= ebit - IW'(1);
          end else begin
            t    <= t_step;
            mcnt <= mcnt - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl: directed scoreboard bench for rsa_modexp_ctrl.
module tb_rsa_modexp_ctrl;

  localparam int W = 26;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0, exp = '0, n = '0;
  logic         busy, done, err;
  logic [W-1:0] result;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  rsa_modexp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of square-and-multiply over the full WIDTH-bit exponent.
  function automatic longint model_pow(input longint b, input longint e, input longint m);
    longint r = 1;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * b) % m;
    end
    return r;
  endfunction

  function automatic int model_lat(input longint b, input longint e, input longint m);
    int pc = 0;
    if (m < 2 || b >= m) return 2;
    for (int i = 0; i < W; i++) pc += int'(e[i]);
`ifdef RSA_MODEXP_CONST_TIME_EN
    return 2 + 2 * W * W;
`else
    return 2 + W * (W + pc);
`endif
  endfunction

  // Drive one request and push its expectation; optionally keep start high
  // with different operands to show that non-IDLE starts are ignored.
  task automatic applyStimulus(input longint b, input longint e, input longint m,
                               input bit hold);
    exp_t x;
    @(negedge clk);
    base = W'(b); exp = W'(e); n = W'(m); start = 1'b1;
    start_cyc = cyc;
    x.err = (m < 2 || b >= m);
    x.res = x.err ? '0 : W'(model_pow(b, e, m));
    x.lat = model_lat(b, e, m);
    sb.push_back(x);
    @(negedge clk);
    if (hold) begin
      base = W'(3); exp = W'(7); n = W'(33);
    end else begin
      start = 1'b0;
    end
    total++;
    assert (busy === 1'b1) else begin
      bad++; $error("[TB] FAIL busy_after_start: got=%b want=1", busy);
    end
  endtask

  // Wait (bounded) for done, then check result, err, latency and pulse width.
  task automatic checkOutput(input string tag);
    exp_t x;
    bit   seen = 0;
    int   lat;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    x = sb.pop_front();
    lat = cyc - start_cyc;
    total++;
    assert (seen) else begin
      bad++; $error("[TB] FAIL %s_timeout: done=%b want=1", tag, done);
    end
    if (seen) begin
      total++;
      assert (result === x.res) else begin
        bad++; $error("[TB] FAIL %s_result: got=%0d want=%0d", tag, result, x.res);
      end
      total++;
      assert (err === x.err) else begin
        bad++; $error("[TB] FAIL %s_err: got=%b want=%b", tag, err, x.err);
      end
      total++;
      assert (lat === x.lat) else begin
        bad++; $error("[TB] FAIL %s_latency: got=%0d want=%0d", tag, lat, x.lat);
      end
      @(negedge clk);
      total++;
      assert (done === 1'b0 && busy === 1'b0) else begin
        bad++; $error("[TB] FAIL %s_pulse: done=%b busy=%b want 0 0", tag, done, busy);
      end
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    bit extra_done;
    longint c;

    repeat (3) @(negedge clk);
    total++;
    assert (busy === 1'b0 && done === 1'b0 && err === 1'b0 && result === '0) else begin
      bad++; $error("[TB] FAIL reset_state: busy=%b done=%b err=%b result=%0d want 0",
                    busy, done, err, result);
    end
    rst_n = 1'b1;

    applyStimulus(2, 5, 35, 0);  checkOutput("enc_2_5_35");
    applyStimulus(32, 5, 35, 0); checkOutput("dec_32_5_35");
    applyStimulus(9, 0, 35, 0);  checkOutput("exp_zero");
    applyStimulus(0, 0, 35, 0);  checkOutput("base0_exp0");
    applyStimulus(0, 9, 35, 0);  checkOutput("base0");
    applyStimulus(40, 5, 35, 0); checkOutput("base_ge_n");
    applyStimulus(9, 5, 1, 0);   checkOutput("n_lt_2");
    applyStimulus(35, 3, 35, 0); checkOutput("base_eq_n");
    applyStimulus(12345678, 65537, 60000011, 0); checkOutput("large");

    // start held high across the whole operation with other operands
    applyStimulus(2, 5, 35, 1);
    checkOutput("held_start");
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done = 1;
    end
    total++;
    assert (extra_done === 1'b0) else begin
      bad++; $error("[TB] FAIL held_start_second_done: got=%b want=0", extra_done);
    end

    // asynchronous reset in the middle of an operation
    applyStimulus(3, 5, 35, 0);
    repeat (498) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    assert (busy === 1'b0 && done === 1'b0 && result === '0 && err === 1'b0) else begin
      bad++; $error("[TB] FAIL mid_reset: busy=%b done=%b result=%0d err=%b want 0",
                    busy, done, result, err);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7, 5, 35, 0); checkOutput("after_reset");

    // encrypt every residue of 35 and decrypt it back
    for (int b = 0; b < 35; b++) begin
      applyStimulus(b, 5, 35, 0);
      checkOutput("sweep_enc");
      c = model_pow(b, 5, 35);
      applyStimulus(c, 5, 35, 0);
      checkOutput("sweep_dec");
      total++;
      assert (result === W'(b)) else begin
        bad++; $error("[TB] FAIL sweep_recover: got=%0d want=%0d", result, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
RSA_MODEXP_CTRL -- requirements
Module: rsa_modexp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 26, setting the operand, exponent and modulus width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port base, input, WIDTH bits: message or ciphertext operand, captured at start.
REQ-006 The block SHALL have port exp, input, WIDTH bits: exponent (e or d), captured at start.
REQ-007 The block SHALL have port n, input, WIDTH bits: modulus, captured at start.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the accepting edge until DONE is left.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port err, output, 1 bit: operand error flag, valid while done=1.
REQ-011 The block SHALL have port result, output, WIDTH bits: base^exp mod n, held until the next accepted start.

Function
REQ-012 States SHALL be IDLE, LOAD, SQR, MUL and DONE, held in a registered FSM.
REQ-013 In IDLE with start=1, the block SHALL capture base, exp and n, set busy, and go to LOAD on that edge.
REQ-014 start SHALL be ignored in every state except IDLE.
REQ-015 In LOAD, if n<2 or base>=n, the block SHALL set err=1, set result=0, and go to DONE.
REQ-016 In LOAD, otherwise, the block SHALL set acc=1, set bit index to WIDTH-1, and go to SQR.
REQ-017 SQR SHALL compute acc=acc*acc mod n; MUL SHALL compute acc=acc*base mod n.
REQ-018 Each SQR or MUL SHALL use interleaved shift-add modular multiplication, one multiplier bit per cycle, MSB first, exactly WIDTH cycles.
REQ-019 Per cycle, the step SHALL be: t=2t; if t>=n then t-=n; if bit then t+=b; if t>=n then t-=n.
REQ-020 Internal modular-multiply datapath width SHALL be WIDTH+2 bits so that no overflow can occur.
REQ-021 Exponent bits SHALL be scanned MSB to LSB.
REQ-022 After MUL for bit 0, the FSM SHALL go to DONE; otherwise it SHALL decrement the bit index and return to SQR.
REQ-023 In DONE, the block SHALL assert done for exactly one cycle, load result, return to IDLE, and clear busy on the same edge.
REQ-024 exp=0 SHALL yield result=1 with err=0 when n>=2 and base<n.
REQ-025 base=0 SHALL yield result=0, except when exp=0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, result=0, and clear all internal registers, including during an operation.
REQ-027 After rst_n is released, the block SHALL accept start on the first rising edge.

Configuration
REQ-028 The configuration macro SHALL be RSA_MODEXP_CONST_TIME_EN.
REQ-029 With RSA_MODEXP_CONST_TIME_EN defined, MUL SHALL execute for every exponent bit, with its result discarded when the bit is 0.
REQ-030 With the macro defined, start-to-done latency SHALL be exactly 2 + 2*WIDTH*WIDTH cycles, which is 1354 for WIDTH=26.
REQ-031 With the macro undefined, MUL SHALL be skipped when the exponent bit is 0.
REQ-032 With the macro undefined, latency SHALL be 2 + WIDTH*(WIDTH + popcount(exp)) cycles.
REQ-033 The error path SHALL have 2-cycle latency with or without the macro.

Verification
REQ-034 base=2, exp=5, n=35 -> result=32, err=0, done exactly 1354 cycles after start with the macro (2+26*28=730 without).
REQ-035 base=32, exp=5, n=35 -> result=2, which decrypts the scenario-1 output.
REQ-036 base=9, exp=0, n=35 -> result=1; base=40, n=35 -> err=1 and result=0; n=1 -> err=1, each with done 2 cycles after start.
REQ-037 start held high during busy, with different operands -> ignored; result equals the first request's result, and done pulses once.
REQ-038 rst_n pulled low at cycle 500 of an operation -> busy, done and result read 0 at once; a new start then completes with the correct result.
REQ-039 Sweep base 0..34, exp=5, n=35, then decrypt each result with exp=5 -> recovered value equals the original base every time.
